// File: rtl/mdio_slave.sv
// rtl/mdio_slave.sv - Clause-22 MDIO management responder (PHY side)
module mdio_slave #(
  parameter int SYNC_STAGES  = 2,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  phy_addr,
  input  logic        mdc_in,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        busy,
  output logic        frame_err
);
  typedef enum logic [2:0] {IDLE, ST2, OP, PHYAD, REGAD, TA1, TA2, DATA} state_t;
  localparam logic [5:0] PRE_LEN = 6'(PREAMBLE_LEN);

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] mdc_sync, mdio_sync;
  logic                   mdc_prev, mdc_s, mdio_s, mre;
  logic [5:0]             pre_cnt;
  logic [3:0]             bit_cnt;
  logic [15:0]            shreg;
  logic                   is_read, rd_pend, op_ok;
  logic [1:0]             op_bits;
  logic [4:0]             field5;

  assign mdc_s   = mdc_sync[SYNC_STAGES-1];
  assign mdio_s  = mdio_sync[SYNC_STAGES-1];
  assign mre     = mdc_s & ~mdc_prev;
  assign op_bits = {shreg[0], mdio_s};
  assign field5  = {shreg[3:0], mdio_s};
  assign op_ok   = (op_bits == 2'b10) || (op_bits == 2'b01);

  // Synchronizers reset to the idle-high level so reset release never fakes an MDC edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mdc_sync  <= '1;
      mdio_sync <= '1;
      mdc_prev  <= 1'b1;
    end else begin
      mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc_in};
      mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_in};
      mdc_prev  <= mdc_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (mre) begin
      case (state)
        IDLE:    if (!mdio_s && pre_cnt >= PRE_LEN) state_next = ST2;
        ST2:     state_next = mdio_s ? OP : IDLE;
        OP:      if (bit_cnt == 4'd1) state_next = op_ok ? PHYAD : IDLE;
        PHYAD:   if (bit_cnt == 4'd4) state_next = (field5 == phy_addr) ? REGAD : IDLE;
        REGAD:   if (bit_cnt == 4'd4) state_next = TA1;
        TA1:     state_next = TA2;
        TA2:     state_next = DATA;
        DATA:    if (bit_cnt == 4'd15) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mdio_out  <= 1'b1;
      mdio_oe   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      is_read   <= 1'b0;
      rd_pend   <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
      busy      <= (state_next != IDLE);
      rd_pend   <= reg_rd;
      // Register block answers one clk after the strobe; capture it then.
      if (rd_pend) shreg <= reg_rdata;
      if (mre) begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            if (mdio_s) pre_cnt <= (pre_cnt == 6'h3f) ? pre_cnt : pre_cnt + 6'd1;
            else        pre_cnt <= '0;
          end
          ST2: begin
            bit_cnt <= '0;
            if (!mdio_s) frame_err <= 1'b1;
          end
          OP: begin
            shreg   <= {shreg[14:0], mdio_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd1) begin
              bit_cnt   <= '0;
              is_read   <= (op_bits == 2'b10);
              frame_err <= ~op_ok;
            end
          end
          PHYAD, REGAD: begin
            shreg   <= {shreg[14:0], mdio_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd4) begin
              bit_cnt <= '0;
              if (state == REGAD) begin
                reg_addr <= field5;
                reg_rd   <= is_read;
              end
            end
          end
          TA1: begin
            if (is_read) begin
              mdio_oe  <= 1'b1;
              mdio_out <= 1'b0;
            end
          end
          TA2: begin
            bit_cnt <= '0;
            if (is_read) begin
              mdio_out <= shreg[15];
              shreg    <= {shreg[14:0], 1'b0};
            end
          end
          DATA: begin
            bit_cnt <= bit_cnt + 4'd1;
            if (is_read) begin
              if (bit_cnt == 4'd15) begin
                mdio_oe  <= 1'b0;
                mdio_out <= 1'b1;
              end else begin
                mdio_out <= shreg[15];
                shreg    <= {shreg[14:0], 1'b0};
              end
            end else begin
              shreg <= {shreg[14:0], mdio_s};
              if (bit_cnt == 4'd15) begin
                reg_wdata <= {shreg[14:0], mdio_s};
                reg_we    <= 1'b1;
              end
            end
          end
          default: bit_cnt <= '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mdio_slave.sv
// tb/tb_mdio_slave.sv - randomized bench for mdio_slave against a frame-level reference model
module tb_mdio_slave;
  localparam int HALF = 6;
  localparam int PRE  = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  phy_addr = 5'd1;
  logic        mdc_in = 1'b0;
  logic        master_val = 1'b1;
  logic        mdio_in, mdio_out, mdio_oe, reg_we, reg_rd, busy, frame_err;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata, reg_rdata;
  logic [15:0] rom [32];

  int checks = 0, failures = 0;
  int we_cnt = 0, rd_cnt = 0, ferr_cnt = 0, busy_clks = 0, both_cnt = 0;
  logic [4:0]  we_addr = '0, rd_addr = '0;
  logic [15:0] we_data = '0;

  always #5 clk = ~clk;

  // Shared pad: the slave wins while it drives, otherwise the master's value.
  assign mdio_in = mdio_oe ? mdio_out : master_val;

  mdio_slave #(.SYNC_STAGES(2), .PREAMBLE_LEN(PRE)) dut (
    .clk(clk), .reset(reset), .phy_addr(phy_addr), .mdc_in(mdc_in), .mdio_in(mdio_in),
    .mdio_out(mdio_out), .mdio_oe(mdio_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_rd(reg_rd), .reg_rdata(reg_rdata), .busy(busy), .frame_err(frame_err)
  );

  always @(posedge clk) if (reg_rd) reg_rdata <= rom[reg_addr];

  always @(negedge clk) begin
    if (!reset) begin
      if (reg_we) begin we_cnt++; we_addr = reg_addr; we_data = reg_wdata; end
      if (reg_rd) begin rd_cnt++; rd_addr = reg_addr; end
      if (frame_err) ferr_cnt++;
      if (busy) busy_clks++;
      if (reg_we && reg_rd) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic oe_s, output logic out_s);
    master_val = b;
    repeat (HALF) @(negedge clk);
    oe_s = mdio_oe;
    out_s = mdio_out;
    mdc_in = 1'b1;
    repeat (HALF) @(negedge clk);
    mdc_in = 1'b0;
  endtask

  task automatic run_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                           input logic [4:0] phy, input logic [4:0] ra,
                           input logic [15:0] wd, input int abort_bit);
    logic q[$];
    int ta2, oe_bad, we0, rd0, fe0, bz0;
    logic started, bad, hit, exp_rd, exp_wr, exp_oe, oe_s, out_s, ta_v;
    logic [15:0] rword;
    q.push_back(1'b0);
    for (int i = 0; i < pre; i++) q.push_back(1'b1);
    q.push_back(st[1]); q.push_back(st[0]);
    q.push_back(op[1]); q.push_back(op[0]);
    for (int i = 4; i >= 0; i--) q.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) q.push_back(ra[i]);
    ta2 = q.size() + 1;
    q.push_back(1'b1);
    q.push_back(op == 2'b10);
    for (int i = 15; i >= 0; i--) q.push_back((op == 2'b10) ? 1'b1 : wd[i]);
    q.push_back(1'b1);

    started = (pre >= PRE) && (st[1] == 1'b0);
    bad     = started && (st[0] == 1'b0 || !(op == 2'b10 || op == 2'b01));
    hit     = started && !bad && (phy == phy_addr);
    exp_rd  = hit && (op == 2'b10);
    exp_wr  = hit && (op == 2'b01);

    we0 = we_cnt; rd0 = rd_cnt; fe0 = ferr_cnt; bz0 = busy_clks;
    oe_bad = 0; rword = '0; ta_v = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      if (abort_bit >= 0 && i == ta2 + 1 + abort_bit) begin
        check("abort_oe_before", mdio_oe, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_oe", mdio_oe, 0);
        check("abort_busy", busy, 0);
        check("abort_out", mdio_out, 1);
        reset = 1'b0;
        @(negedge clk);
        return;
      end
      send_bit(q[i], oe_s, out_s);
      exp_oe = exp_rd && (i >= ta2) && (i <= ta2 + 16);
      if (oe_s !== exp_oe) oe_bad++;
      if (i == ta2) ta_v = out_s;
      if (i > ta2 && i <= ta2 + 16) rword = {rword[14:0], out_s};
    end
    repeat (HALF) @(negedge clk);

    check("we_count", we_cnt - we0, exp_wr);
    check("rd_count", rd_cnt - rd0, exp_rd);
    check("frame_err_count", ferr_cnt - fe0, bad);
    check("busy_seen", (busy_clks - bz0) > 0, started);
    check("busy_end", busy, 0);
    check("oe_pattern_errs", oe_bad, 0);
    if (exp_wr) begin
      check("we_addr", we_addr, ra);
      check("we_data", we_data, wd);
    end
    if (exp_rd) begin
      check("rd_addr", rd_addr, ra);
      check("rd_ta", ta_v, 0);
      check("rd_data", rword, rom[ra]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
    rom[2] = 16'h1234;
    repeat (3) @(negedge clk);
    check("rst_mdio_out", mdio_out, 1);
    check("rst_mdio_oe", mdio_oe, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_strobes", {reg_we, reg_rd, frame_err, busy}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    run_frame(32, 2'b01, 2'b01, 5'd1, 5'h04, 16'hA5C3, -1);
    run_frame(32, 2'b01, 2'b10, 5'd1, 5'h02, 16'h0000, -1);
    run_frame(32, 2'b01, 2'b10, 5'd5, 5'h02, 16'h0000, -1);
    run_frame(31, 2'b01, 2'b01, 5'd1, 5'h06, 16'h5A5A, -1);
    run_frame(32, 2'b01, 2'b01, 5'd1, 5'h07, 16'h0F0F, -1);
    run_frame(32, 2'b01, 2'b11, 5'd1, 5'h03, 16'h1111, -1);
    run_frame(32, 2'b00, 2'b01, 5'd1, 5'h03, 16'h2222, -1);
    run_frame(32, 2'b01, 2'b10, 5'd1, 5'h02, 16'h0000, 8);
    run_frame(32, 2'b01, 2'b10, 5'd1, 5'h1F, 16'h0000, -1);

    for (int n = 0; n < 20; n++) begin
      logic [1:0] op, st;
      logic [4:0] phy;
      int pre;
      phy_addr = 5'($urandom);
      case ($urandom_range(5, 0))
        0, 1, 2: op = 2'b10;
        3, 4:    op = 2'b01;
        default: op = 2'($urandom);
      endcase
      st  = ($urandom_range(9, 0) == 0) ? 2'b00 : 2'b01;
      phy = ($urandom_range(9, 0) < 7) ? phy_addr : 5'($urandom);
      pre = $urandom_range(34, 30);
      run_frame(pre, st, op, phy, 5'($urandom), 16'($urandom), -1);
    end

    check("we_rd_overlap", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdio_slave.md
Name: mdio_slave

Overview:
- PHY-side Clause-22 MDIO management responder; the far end of the team's MDIO master.
- Oversamples MDC/MDIO on the system clock, decodes frames, and issues register-file read/write strobes.
- Drives the read turnaround and data bits back on the shared MDIO line via a tristate enable.
- Sits between the pad-level MDIO/MDC pins and the PHY's local register block.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on mdc_in and mdio_in (minimum 2).
- PREAMBLE_LEN, 32, consecutive 1 bits required before a start-of-frame is accepted (1..32).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- phy_addr  input  5  strapped PHY address this slave answers to; static.
- mdc_in  input  1  MDC from pad, asynchronous to clk.
- mdio_in  input  1  MDIO pad input, asynchronous to clk.
- mdio_out  output  1  MDIO value driven when mdio_oe=1.
- mdio_oe  output  1  tristate enable for MDIO pad (1 = slave drives).
- reg_addr  output  5  register address for the current access.
- reg_wdata  output  16  write data; valid while reg_we=1.
- reg_we  output  1  one-clk write strobe.
- reg_rd  output  1  one-clk read strobe.
- reg_rdata  input  16  read data; must be valid on the clk after reg_rd.
- busy  output  1  high from accepted ST until frame end or abort.
- frame_err  output  1  one-clk pulse on a malformed frame after ST.

Behaviour:
- Reset values: mdio_out=1, mdio_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_rd=0, busy=0, frame_err=0.
- Reset mid-frame: state returns to IDLE, the preamble count clears, and mdio_oe drops on the clk after reset is sampled.
- Sampling:
  - mdc_in and mdio_in each pass through SYNC_STAGES flops.
  - An MDC rising edge (mre) is detected when synced MDC=1 and its previous value=0.
  - All bit sampling uses synced mdio_in on the mre clk.
  - MDC high and low phases are each at least SYNC_STAGES+2 clk periods.
- Bit numbering: the MSB of every field is received or sent first.
- Frame decode (state machine, advances only on mre):
  - IDLE:
    - Sampled 1 increments a saturating preamble count (6 bits).
    - Sampled 0 with count >= PREAMBLE_LEN -> ST2, busy=1.
    - Sampled 0 with count < PREAMBLE_LEN -> clear count and stay in IDLE.
  - ST2: expect 1 -> OP; otherwise frame_err, go to IDLE.
  - OP: collect 2 bits. 10 = read, 01 = write; 00 or 11 -> frame_err, go to IDLE.
  - PHYAD: collect 5 bits. If the result differs from phy_addr -> IDLE silently (no frame_err, busy=0, no strobes, never drives).
  - REGAD: collect 5 bits; reg_addr is updated on the 5th bit. On that mre (edge R), for reads only, reg_rd pulses on the following clk.
  - TA1: sampled at R+1. For reads, reg_rdata is latched into the 16-bit shift register on the clk after reg_rd.
  - TA2 (sampled at R+2):
    - Reads: after mre R+1, mdio_oe=1 and mdio_out=0.
    - Writes: the TA bits are ignored, with no checking.
  - DATA (16 bits, sampled R+3..R+18):
    - Reads: after each mre R+2..R+17, mdio_out shifts the next data bit, bit 15 first. After mre R+18, mdio_oe=0 and mdio_out=1, then go to IDLE.
    - Writes: shift in 16 bits. After the 16th (R+18), reg_wdata updates and reg_we pulses one clk, then go to IDLE.
  - busy clears on the same clk the state returns to IDLE.
- Output changes occur on the clk after the mre that triggers them (registered).
- The preamble count is cleared whenever the state leaves IDLE.
- Back-to-back frames require a full preamble each time.
- reg_we and reg_rd are never both high; each fires at most once per frame.
- Ignored frames (address mismatch, aborts) produce no reg_we/reg_rd.

Test Plan:
- phy_addr=1; 32 ones, write frame PHY=1 REG=0x04 DATA=0xA5C3 -> single reg_we pulse with reg_addr=0x04, reg_wdata=0xA5C3; mdio_oe stays 0.
- phy_addr=1; read frame REG=0x02, reg_rdata=0x1234 -> one reg_rd; bits sampled R+2..R+18 read 0 then 0x1234 MSB first; mdio_oe=1 only across those 17 bits.
- Read frame to PHY=5 while phy_addr=1 -> no strobes, mdio_oe=0, frame_err=0, busy returns 0 after PHYAD.
- Preamble of 31 ones then ST -> frame ignored. Then 32 ones plus a valid write -> accepted.
- OP=11 after valid ST -> frame_err pulse, IDLE, no strobes. ST=00 -> frame_err.
- Assert reset during read DATA bit 8 -> mdio_oe=0, busy=0 next clk. A following full read frame completes correctly.
